// File: rtl/dac_fmt_pkg.sv
// Shared types and helpers for the axis_dac_formatter slice: shift FSM states,
// default scaler, and the saturate/offset-binary helper used by dac_fmt_sat.
package dac_fmt_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } fmt_state_e;

    localparam int DEFAULT_SCALER = 12;

    // Working width of the helper; callers sign-extend into it.
    localparam int SAT_W = 64;

    // Returns {offset-binary code (low dac_width bits valid, rest 0), sat_hit}.
    function automatic logic [SAT_W:0] sat_offset(input logic signed [SAT_W-1:0] value,
                                                  input int dac_width);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] sat_v;
        logic [SAT_W-1:0]        msb_v;
        logic [SAT_W-1:0]        mask_v;
        logic                    hit_v;
        max_v = (64'sd1 <<< (dac_width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (dac_width - 1));
        if (value > max_v) begin
            sat_v = max_v;
            hit_v = 1'b1;
        end else if (value < min_v) begin
            sat_v = min_v;
            hit_v = 1'b1;
        end else begin
            sat_v = value;
            hit_v = 1'b0;
        end
        msb_v  = 64'd1 << (dac_width - 1);
        mask_v = (64'd1 << dac_width) - 64'd1;
        return {(sat_v ^ msb_v) & mask_v, hit_v};
    endfunction

endpackage

// File: rtl/dac_fmt_sat.sv
// Combinational saturate-to-DAC_WIDTH and two's-complement to offset-binary
// conversion; the code is zero-extended to OUT_WIDTH.
module dac_fmt_sat
    import dac_fmt_pkg::*;
#(
    parameter int IN_W      = 33,
    parameter int DAC_WIDTH = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic signed [IN_W-1:0]      value,
    output logic        [OUT_WIDTH-1:0] code,
    output logic                        sat_hit
);

    logic [SAT_W:0] res_s;

    assign res_s   = sat_offset(SAT_W'(value), DAC_WIDTH);
    assign code    = OUT_WIDTH'(res_s[SAT_W:1]);
    assign sat_hit = res_s[0];

endmodule

// File: rtl/axis_dac_formatter.sv
// AXI-Stream sample-to-DAC formatter: scale/round, saturate, offset-binary, 2-stage
// registered pipeline. Optional sat_count port enabled by DAC_FMT_SAT_COUNT_EN.
module axis_dac_formatter
    import dac_fmt_pkg::*;
#(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 32,
    parameter int DAC_WIDTH   = 8,
    parameter int SCALER      = DEFAULT_SCALER,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_aresetn,
    input  logic [IN_WIDTH-1:0]      s00_axis_tdata,
    input  logic                     s00_axis_tvalid,
    input  logic                     s00_axis_tlast,
    output logic                     s00_axis_tready,
    output logic [OUT_WIDTH-1:0]     m00_axis_tdata,
    output logic                     m00_axis_tvalid,
    output logic                     m00_axis_tlast,
    output logic [OUT_WIDTH/8-1:0]   m00_axis_tstrb,
    input  logic                     m00_axis_tready,
    input  logic [SHIFT_WIDTH-1:0]   shift,
    input  logic                     round_en,
    output logic                     sat_flag,
    input  logic                     sat_clear
`ifdef DAC_FMT_SAT_COUNT_EN
    ,
    output logic [15:0]              sat_count
`endif
);

    logic                   en1_s, en2_s, accept_s, load2_s;
    logic                   v1_r, l1_r, v2_r;
    logic signed [IN_WIDTH:0] d1_r;
    fmt_state_e             state_r, state_nxt_s;
    logic [SHIFT_WIDTH-1:0] shift_r, shift_eff_s;
    logic                   shift_load_s;
    logic [7:0]             n_sum_s, n_s;
    logic signed [IN_WIDTH:0] ext_s, rnd_s, shifted_s;
    logic [OUT_WIDTH-1:0]   code_s;
    logic                   hit_s;

    assign en2_s           = ~v2_r | m00_axis_tready;
    assign en1_s           = ~v1_r | en2_s;
    assign s00_axis_tready = en1_s;
    assign accept_s        = s00_axis_tvalid & en1_s;
    assign load2_s         = en2_s & v1_r;
    assign m00_axis_tvalid = v2_r;
    assign m00_axis_tstrb  = {(OUT_WIDTH/8){1'b1}};

    // FSM state register
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) state_r <= IDLE;
        else                   state_r <= state_nxt_s;
    end

    // FSM next state: packet boundaries are tracked on accepted beats only
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (accept_s && !s00_axis_tlast) state_nxt_s = IN_PKT;
                     else                             state_nxt_s = IDLE;
            IN_PKT:  if (accept_s && s00_axis_tlast)  state_nxt_s = IDLE;
                     else                             state_nxt_s = IN_PKT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: shift tracks the input only between packets
    always_comb begin
        shift_load_s = 1'b0;
        if (state_r == IDLE) shift_load_s = 1'b1;
        else                 shift_load_s = 1'b0;
    end

    // Held shift value for the current packet
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) shift_r <= '0;
        else if (shift_load_s) shift_r <= shift;
        else                   shift_r <= shift_r;
    end

    // Stage 1 datapath: the first beat of a packet sees the live shift it is latched with
    always_comb begin
        shift_eff_s = shift_r;
        if (shift_load_s) shift_eff_s = shift;
        else              shift_eff_s = shift_r;
        n_sum_s = 8'(SCALER) + 8'(shift_eff_s);
        if (n_sum_s > 8'(IN_WIDTH - 1)) n_s = 8'(IN_WIDTH - 1);
        else                            n_s = n_sum_s;
        ext_s = {s00_axis_tdata[IN_WIDTH-1], s00_axis_tdata};
        if (round_en && (n_s != 8'd0)) rnd_s = ext_s + ((IN_WIDTH + 1)'(1'b1) << (n_s - 8'd1));
        else                           rnd_s = ext_s;
        shifted_s = rnd_s >>> n_s;
    end

    // Stage 1 register
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            v1_r <= 1'b0;
            d1_r <= '0;
            l1_r <= 1'b0;
        end else if (en1_s) begin
            v1_r <= s00_axis_tvalid;
            if (s00_axis_tvalid) begin
                d1_r <= shifted_s;
                l1_r <= s00_axis_tlast;
            end
        end
    end

    dac_fmt_sat #(
        .IN_W      (IN_WIDTH + 1),
        .DAC_WIDTH (DAC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .value   (d1_r),
        .code    (code_s),
        .sat_hit (hit_s)
    );

`ifdef DAC_FMT_SAT_COUNT_EN
    logic hit2_r;
    logic inc_s;
    assign inc_s = v2_r & m00_axis_tready & hit2_r;

    // Saturated-beat counter, counted on output handshake
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn)              sat_count <= 16'd0;
        else if (sat_clear && inc_s)        sat_count <= 16'd1;
        else if (sat_clear)                 sat_count <= 16'd0;
        else if (inc_s && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
    end

    // Saturation tag travelling with the stage 2 beat
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn)  hit2_r <= 1'b0;
        else if (load2_s)       hit2_r <= hit_s;
    end
`endif

    // Stage 2 register, doubling as the output register
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            v2_r           <= 1'b0;
            m00_axis_tdata <= '0;
            m00_axis_tlast <= 1'b0;
        end else if (en2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                m00_axis_tdata <= code_s;
                m00_axis_tlast <= l1_r;
            end
        end
    end

    // Sticky saturation flag; a new saturation outranks a clear
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn)      sat_flag <= 1'b0;
        else if (load2_s && hit_s)  sat_flag <= 1'b1;
        else if (sat_clear)         sat_flag <= 1'b0;
    end

endmodule
